// File: rtl/ymat_pkg.sv
// ymat_pkg: shared FSM states and pointer-word field helpers for the Y-matrix row fetch path.
package ymat_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PTR_RD, S_PTR_WAIT, S_ISSUE, S_DONE} state_e;
  localparam int FIELDS_PER_PAIR = 2;
  function automatic int pairs_of(input int word_w, input int field_w);
    return word_w / (FIELDS_PER_PAIR * field_w);
  endfunction
  function automatic int field_lsb(input int sel, input int hi, input int field_w);
    return (FIELDS_PER_PAIR * sel + hi) * field_w;
  endfunction
endpackage

// File: rtl/ymat_addr_lane.sv
// ymat_addr_lane: one data channel's enable and address for the current issue base.
module ymat_addr_lane #(
  parameter int ADDR_W = 11,
  parameter int LANE   = 0
) (
  input  logic [ADDR_W:0]   base_i,
  input  logic [ADDR_W:0]   end_i,
  output logic              en_o,
  output logic [ADDR_W-1:0] addr_o
);
  logic [ADDR_W+1:0] pos;
  assign pos    = {1'b0, base_i} + (ADDR_W+2)'(LANE);
  assign en_o   = pos < {1'b0, end_i};
  assign addr_o = en_o ? pos[ADDR_W-1:0] : '0;
endmodule

// File: rtl/ymat_row_fetch.sv
// ymat_row_fetch: reads a row's {end,start} pointer pair and streams its data-SRAM addresses over NUM_CH lanes.
module ymat_row_fetch
  import ymat_pkg::*;
#(
  parameter int ROW_W      = 15,
  parameter int ADDR_W     = 11,
  parameter int FIELD_W    = 16,
  parameter int PTR_WORD_W = 256,
  parameter int PTR_ADDR_W = 8,
  parameter int NUM_CH     = 2,
  parameter int RD_LAT     = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [ROW_W-1:0]         req_row,
  output logic                     req_ready,
  input  logic                     abort,
  output logic                     ptr_rd_en,
  output logic [PTR_ADDR_W-1:0]    ptr_addr,
  input  logic [PTR_WORD_W-1:0]    ptr_rdata,
  output logic [NUM_CH-1:0]        dat_en,
  output logic [NUM_CH*ADDR_W-1:0] dat_addr,
  output logic [ADDR_W-1:0]        row_start,
  output logic [ADDR_W:0]          row_len,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);
  localparam int PAIRS  = pairs_of(PTR_WORD_W, FIELD_W);
  localparam int LOG2P  = $clog2(PAIRS);
  localparam int SEL_W  = LOG2P > 0 ? LOG2P : 1;
  localparam int IDX_W  = $clog2(PTR_WORD_W);
  localparam int WAIT_W = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  state_e state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [ADDR_W:0] cur_q, cur_d, end_q, end_d;
  logic req_ready_q, req_ready_d, ptr_rd_en_q, ptr_rd_en_d, busy_q, busy_d;
  logic done_q, done_d, err_q, err_d, issue;
  logic [PTR_ADDR_W-1:0] ptr_addr_q, ptr_addr_d;
  logic [NUM_CH-1:0] dat_en_q, dat_en_d, lane_en;
  logic [NUM_CH*ADDR_W-1:0] dat_addr_q, dat_addr_d, lane_addr;
  logic [ADDR_W-1:0] row_start_q, row_start_d, s;
  logic [ADDR_W:0] row_len_q, row_len_d, e, base, lim;
  logic [IDX_W-1:0] lo_idx, hi_idx;
  assign lo_idx = IDX_W'(field_lsb(int'(sel_q), 0, FIELD_W));
  assign hi_idx = IDX_W'(field_lsb(int'(sel_q), 1, FIELD_W));
  assign s      = ptr_rdata[lo_idx +: ADDR_W];
  assign e      = ptr_rdata[hi_idx +: ADDR_W+1];
  // The capture cycle already drives the first issue beat, so lanes see the raw pointer there.
  assign base   = state_q == S_PTR_WAIT ? {1'b0, s} : cur_q;
  assign lim    = state_q == S_PTR_WAIT ? e : end_q;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    ymat_addr_lane #(.ADDR_W(ADDR_W), .LANE(k)) u_lane (
      .base_i(base),
      .end_i (lim),
      .en_o  (lane_en[k]),
      .addr_o(lane_addr[k*ADDR_W +: ADDR_W])
    );
  end
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    sel_d       = sel_q;
    cur_d       = cur_q;
    end_d       = end_q;
    row_start_d = row_start_q;
    row_len_d   = row_len_q;
    req_ready_d = 1'b0;
    ptr_rd_en_d = 1'b0;
    ptr_addr_d  = '0;
    issue       = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          state_d     = S_PTR_RD;
          req_ready_d = 1'b0;
          ptr_rd_en_d = 1'b1;
          ptr_addr_d  = PTR_ADDR_W'(req_row >> LOG2P);
          sel_d       = SEL_W'(req_row & ROW_W'(PAIRS - 1));
        end
      end
      S_PTR_RD: begin
        state_d = S_PTR_WAIT;
        wait_d  = '0;
      end
      S_PTR_WAIT: begin
        if (wait_q == WAIT_W'(RD_LAT - 1)) begin
          row_start_d = s;
          row_len_d   = e > {1'b0, s} ? e - {1'b0, s} : '0;
          end_d       = e;
          cur_d       = {1'b0, s} + (ADDR_W+1)'(NUM_CH);
          issue       = e > {1'b0, s};
          state_d     = e > {1'b0, s} ? S_ISSUE : S_DONE;
          done_d      = e <= {1'b0, s};
          err_d       = e < {1'b0, s};
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_ISSUE: begin
        issue   = cur_q < end_q;
        cur_d   = cur_q < end_q ? cur_q + (ADDR_W+1)'(NUM_CH) : cur_q;
        state_d = cur_q < end_q ? S_ISSUE : S_DONE;
        done_d  = cur_q >= end_q;
      end
      S_DONE: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d     = S_IDLE;
      req_ready_d = 1'b1;
      ptr_rd_en_d = 1'b0;
      ptr_addr_d  = '0;
      issue       = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      row_start_d = row_start_q;
      row_len_d   = row_len_q;
    end
    dat_en_d   = issue ? lane_en : '0;
    dat_addr_d = issue ? lane_addr : '0;
    busy_d     = state_d != S_IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      sel_q       <= '0;
      cur_q       <= '0;
      end_q       <= '0;
      req_ready_q <= 1'b0;
      ptr_rd_en_q <= 1'b0;
      ptr_addr_q  <= '0;
      dat_en_q    <= '0;
      dat_addr_q  <= '0;
      row_start_q <= '0;
      row_len_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      sel_q       <= sel_d;
      cur_q       <= cur_d;
      end_q       <= end_d;
      req_ready_q <= req_ready_d;
      ptr_rd_en_q <= ptr_rd_en_d;
      ptr_addr_q  <= ptr_addr_d;
      dat_en_q    <= dat_en_d;
      dat_addr_q  <= dat_addr_d;
      row_start_q <= row_start_d;
      row_len_q   <= row_len_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end
  assign req_ready = req_ready_q;
  assign ptr_rd_en = ptr_rd_en_q;
  assign ptr_addr  = ptr_addr_q;
  assign dat_en    = dat_en_q;
  assign dat_addr  = dat_addr_q;
  assign row_start = row_start_q;
  assign row_len   = row_len_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
endmodule

// File: doc/ymat_row_fetch.md
Name: ymat_row_fetch

Overview:
- Parametrised successor to the Y-matrix row-address path (getYMatRow/Controller).
- Accepts a row index over a valid/ready handshake and reads that row's {end,start} pointer pair from the pointer SRAM.
- Then streams the row's data-SRAM addresses across NUM_CH parallel read channels, one address per channel per cycle.
- Sits between the row-scheduling control and the Y-data SRAM ports.

Parameters:
- ROW_W, 15, row index width.
- ADDR_W, 11, data-SRAM address width.
- FIELD_W, 16, width of one pointer field in the pointer word.
- PTR_WORD_W, 256, pointer-SRAM read width; PAIRS = PTR_WORD_W/(2*FIELD_W) = 8 pairs per word.
- PTR_ADDR_W, 8, pointer-SRAM address width.
- NUM_CH, 2, number of data-address channels.
- RD_LAT, 1, pointer-SRAM read latency in cycles (>=1).

Ports:
- clock, in, 1, single clock.
- reset, in, 1, synchronous, active-high.
- req_valid, in, 1, row request valid.
- req_row, in, ROW_W, row index.
- req_ready, out, 1, block can accept a request.
- abort, in, 1, synchronous cancel of the current request.
- ptr_rd_en, out, 1, pointer-SRAM read strobe.
- ptr_addr, out, PTR_ADDR_W, pointer-SRAM word address.
- ptr_rdata, in, PTR_WORD_W, pointer-SRAM read data.
- dat_en, out, NUM_CH, per-channel address valid.
- dat_addr, out, NUM_CH*ADDR_W, channel k occupies bits [k*ADDR_W +: ADDR_W].
- row_start, out, ADDR_W, latched start pointer.
- row_len, out, ADDR_W+1, latched row length (end - start).
- busy, out, 1, high in any non-IDLE state.
- done, out, 1, one-cycle completion pulse.
- err, out, 1, one-cycle pulse, asserted with done, when end < start.

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - req_ready=1 (after reset releases; 0 while reset is high).
  - All other outputs = 0.
  - State = IDLE.
- States: IDLE, PTR_RD, PTR_WAIT, ISSUE, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready (cycle 0), latch req_row and go to PTR_RD.
- PTR_RD (cycle 1):
  - ptr_rd_en=1.
  - ptr_addr = row >> log2(PAIRS), truncated to PTR_ADDR_W.
  - Go to PTR_WAIT.
- PTR_WAIT:
  - Count RD_LAT cycles, then capture ptr_rdata at cycle 1+RD_LAT.
  - sel = row mod PAIRS.
  - start = low ADDR_W bits of field 2*sel.
  - end = low ADDR_W+1 bits of field 2*sel+1 (exclusive; may equal 2^ADDR_W).
  - Load row_start = start and row_len = end - start (0 if end < start).
- Decision after capture:
  - end > start: go to ISSUE with cur = start.
  - end == start: go to DONE, no dat_en.
  - end < start: go to DONE with err=1.
- ISSUE:
  - First issue cycle is 2+RD_LAT.
  - Each cycle, for every k: dat_en[k] = (cur+k < end); dat_addr[k] = (cur+k) mod 2^ADDR_W.
  - Disabled lanes drive dat_addr = 0.
  - cur += NUM_CH, using an ADDR_W+1-bit counter.
  - The last issue cycle is the one where cur+NUM_CH >= end; then go to DONE.
- DONE:
  - done=1 for one cycle (err as decided above).
  - dat_en=0.
  - Return to IDLE; req_ready returns high the following cycle.
- No back-to-back overlap: req_ready=0 from the cycle after acceptance until the state is back in IDLE.
- abort:
  - Sampled in any non-IDLE state; next state is IDLE.
  - From the next cycle: dat_en=0, ptr_rd_en=0, busy=0, and no done/err.
  - row_start/row_len hold their values.
  - abort in IDLE is ignored.
  - If abort and req_valid are both high in IDLE, the request is accepted.
- Reset mid-operation: behaves exactly as the reset values; no done/err pulse.
- Throughput: ceil(len/NUM_CH) issue cycles per row.
- Total request-to-done latency: 2 + RD_LAT + ceil(len/NUM_CH) cycles for len > 0.

Decomposition:
- Shared package ymat_pkg holds:
  - the state enum;
  - the PAIRS/field-extraction constants;
  - the pointer-field index helper function.
- One sub-module, ymat_addr_lane: per-channel combinational enable/address generator, instanced NUM_CH times with generate.
- Only the FSM and counters are registered, in the top module.

Test Plan:
- Reset with req_valid=1 -> all outputs 0, no acceptance; one cycle after reset releases, req_ready=1.
- req_row=10, pair 2 of word 1 = {start=100, end=105}, NUM_CH=2, RD_LAT=1 -> ptr_rd_en with ptr_addr=1 at cycle 1. ISSUE cycles 3-5:
  - cycle 3: addrs 100/101, en=11;
  - cycle 4: addrs 102/103, en=11;
  - cycle 5: addr 104, en=01.
  - done at cycle 6; row_len=5.
- start=end=40 -> no dat_en; done at cycle 3; row_len=0; err=0.
- start=50, end=20 -> done and err high in the same cycle; row_len=0; no dat_en.
- start=2046, end=2048 -> one issue cycle, addrs 2046/2047, en=11; counter does not wrap early.
- abort in the second ISSUE cycle of a len=8 row -> dat_en=0 from the next cycle, no done, req_ready=1 one cycle later. Repeat with RD_LAT=3 and NUM_CH=4 and check the latency formula.
